task_tick_scheduler: RTL

Single-clock periodic task scheduler for the temperature-control design. It replaces chains of derived clocks with one-cycle enable strobes. A programmable prescaler produces a base tick from the 24 MHz system clock. Three per-task period counters then launch three periodic tasks (display scan, sensor sample, control update) through a start/done handshake, with a fixed-priority arbiter and overrun detection.

---
 rtl/task_tick_scheduler.sv | 89 ++++++++
 1 files changed

// File: rtl/task_tick_scheduler.sv
// Periodic task scheduler: prescaled base tick, three period counters, fixed-priority
// launch arbiter with start/done handshake. Define SCHED_OVERRUN_EN for sticky overrun flags.
module task_tick_scheduler #(
    parameter int unsigned CLK_DIV = 2000,
    parameter int unsigned PERIOD0 = 50,
    parameter int unsigned PERIOD1 = 5000,
    parameter int unsigned PERIOD2 = 12000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] task_done,
    input  logic       ovr_clr,
    output logic       base_tick,
    output logic [2:0] task_start,
    output logic [2:0] task_busy,
    output logic [2:0] overrun
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0][15:0] PER_LAST = {16'(PERIOD2 - 1), 16'(PERIOD1 - 1), 16'(PERIOD0 - 1)};

    logic [15:0]      div_cnt;
    logic [2:0][15:0] per_cnt;
    logic [2:0]       pending;
    logic [2:0]       due;
    logic [2:0]       ovr_evt;

    always_comb begin
        due = '0;
        for (int i = 0; i < 3; i++) begin
            due[i] = base_tick && (per_cnt[i] == PER_LAST[i]);
        end
        // A due event finding the task still queued or running is dropped.
        ovr_evt = due & (pending | task_busy);
    end

    // Fixed priority: lowest index wins, one launch per cycle.
    always_comb begin
        task_start = '0;
        if (pending[0] && !task_busy[0]) begin
            task_start = 3'b001;
        end else if (pending[1] && !task_busy[1]) begin
            task_start = 3'b010;
        end else if (pending[2] && !task_busy[2]) begin
            task_start = 3'b100;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            base_tick <= 1'b0;
            per_cnt   <= '0;
            pending   <= '0;
            task_busy <= '0;
        end else begin
            if (enable) begin
                div_cnt   <= (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
                base_tick <= (div_cnt == DIV_LAST);
            end else begin
                base_tick <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (base_tick) begin
                    per_cnt[i] <= due[i] ? 16'd0 : per_cnt[i] + 16'd1;
                end
            end
            pending   <= (pending & ~task_start) | (due & ~pending & ~task_busy);
            // Done in the launch cycle itself cancels the busy flag before it is ever seen.
            task_busy <= (task_busy | task_start) & ~task_done;
        end
    end

`ifdef SCHED_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= '0;
        end else begin
            overrun <= (overrun & ~{3{ovr_clr}}) | ovr_evt;
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr = ovr_clr ^ (^ovr_evt);
    assign overrun    = '0;
`endif

endmodule
